// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Moore control FSM for a multicycle RV32-style datapath.
//               Sequences fetch, decode, address generation, memory access,
//               execute and write-back, and counts retired instructions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1  rising-edge clock
//   rst_n         in   1  asynchronous active-low reset
//   opcode        in   7  instruction-register opcode field
//   mem_ready     in   1  memory handshake, access completes when high
//   ALU_Op        out  2  00 add, 01 sub/compare, 10 funct-decoded
//   ALUSrcA       out  1  0 = PC, 1 = rs1
//   ALUSrcB       out  2  00 rs2, 01 const 4, 10 imm, 11 imm (branch target)
//   IorD .. illegal out 1 datapath enables / illegal-opcode pulse
//   state         out  4  current state code
//   retired_count out 16  retired-instruction counter (wraps)
// ============================================================================
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic [1:0]  ALU_Op,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [15:0] retired_count
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_LOAD_WB   = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ILLEGAL   = 4'd9
  } state_t;

  state_t      r_state;
  logic [6:0]  r_op_q;
  logic [15:0] r_retired_count;
  logic        w_retire;

  // An instruction retires on the edge that leaves its final state; a store
  // only finishes once its write has been accepted by memory.
  assign w_retire = (r_state == S_LOAD_WB) || (r_state == S_ALU_WB) ||
                    (r_state == S_BRANCH)  ||
                    ((r_state == S_MEM_WRITE) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_FETCH;
      r_op_q          <= 7'd0;
      r_retired_count <= 16'd0;
    end else begin
      // Added unconditionally so the counter is rewritten every cycle.
      r_retired_count <= r_retired_count + {15'd0, w_retire};
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_op_q <= opcode;
          case (opcode)
            c_OP_LOAD, c_OP_STORE: r_state <= S_MEM_ADDR;
            c_OP_RTYPE, c_OP_ITYPE: r_state <= S_EXECUTE;
            c_OP_BRANCH:            r_state <= S_BRANCH;
            default:                r_state <= S_ILLEGAL;
          endcase
        end
        S_MEM_ADDR: begin
          r_state <= (r_op_q == c_OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          if (mem_ready) r_state <= S_LOAD_WB;
        end
        S_MEM_WRITE: begin
          if (mem_ready) r_state <= S_FETCH;
        end
        S_EXECUTE:  r_state <= S_ALU_WB;
        S_LOAD_WB,
        S_ALU_WB,
        S_BRANCH,
        S_ILLEGAL:  r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode from the state register. Gating with rst_n keeps every
  // output low while reset is held, even though the state sits in FETCH.
  always_comb begin
    ALU_Op      = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_LOAD_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALU_Op  = 2'b10;
          ALUSrcB = (r_op_q == c_OP_RTYPE) ? 2'b00 : 2'b10;
        end
        S_ALU_WB: begin
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALU_Op      = 2'b01;
          PCWriteCond = 1'b1;
        end
        S_ILLEGAL: begin
          illegal = 1'b1;
        end
        default: begin
          illegal = 1'b0;
        end
      endcase
    end
  end

  assign state         = r_state;
  assign retired_count = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each instruction
//               is expanded into its expected list of state visits; outputs
//               are predicted from the per-state control table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic [1:0]  ALU_Op;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic        RegWrite, MemtoReg, illegal;
  logic [3:0]  state;
  logic [15:0] retired_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_count = 16'd0;
  logic [14:0] w_obs;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ALU_Op(ALU_Op), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .illegal(illegal), .state(state),
    .retired_count(retired_count)
  );

  assign w_obs = {ALU_Op, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                  PCWrite, PCWriteCond, RegWrite, MemtoReg, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control table: what each state must drive.
  function automatic logic [14:0] exp_out(input int st, input logic [6:0] op, input logic mr);
    logic [1:0] aop, srcb;
    logic srca, iord, mrd, mwr, irw, pcw, pcc, rw, m2r, ill;
    {aop, srcb} = 4'b0;
    {srca, iord, mrd, mwr, irw, pcw, pcc, rw, m2r, ill} = 10'b0;
    case (st)
      0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1: srcb = 2'b11;
      2: begin srca = 1; srcb = 2'b10; end
      3: begin iord = 1; mrd = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin iord = 1; mwr = 1; end
      6: begin srca = 1; aop = 2'b10; srcb = (op == 7'b0110011) ? 2'b00 : 2'b10; end
      7: rw = 1;
      8: begin srca = 1; aop = 2'b01; pcc = 1; end
      9: ill = 1;
      default: ;
    endcase
    return {aop, srca, srcb, iord, mrd, mwr, irw, pcw, pcc, rw, m2r, ill};
  endfunction

  // One clock cycle, starting just after a falling edge.
  task automatic step(input int est, input logic [6:0] drv_op, input logic mr,
                      input logic [6:0] iop);
    opcode    = drv_op;
    mem_ready = mr;
    #1;
    chk("state", {28'd0, state}, est);
    chk("outputs", {17'd0, w_obs}, {17'd0, exp_out(est, iop, mr)});
    chk("retired_count", {16'd0, retired_count}, {16'd0, model_count});
    @(negedge clk);
  endtask

  // Run one instruction: sf stall cycles in FETCH, sm in the memory state.
  task automatic run_instr(input logic [6:0] op, input int sf, input int sm);
    int seq[$];
    logic retires;
    retires = 1'b1;
    case (op)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011,
      7'b0010011: seq = '{0, 1, 6, 7};
      7'b1100011: seq = '{0, 1, 8};
      default: begin seq = '{0, 1, 9}; retires = 1'b0; end
    endcase
    foreach (seq[k]) begin
      if (seq[k] == 0) begin
        for (int i = 0; i < sf; i++) step(0, 7'($urandom), 1'b0, op);
        step(0, 7'($urandom), 1'b1, op);
      end else if (seq[k] == 3 || seq[k] == 5) begin
        for (int i = 0; i < sm; i++) step(seq[k], op, 1'b0, op);
        step(seq[k], op, 1'b1, op);
      end else begin
        // mem_ready toggles freely here; it must have no effect.
        step(seq[k], op, 1'($urandom), op);
      end
    end
    if (retires) model_count = model_count + 16'd1;
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] op;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1111111;

    // Reset: everything low, including FETCH's MemRead.
    rst_n = 1'b0; opcode = 7'd0; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_outputs", {17'd0, w_obs}, 32'd0);
    chk("reset_count", {16'd0, retired_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type, no stalls.
    run_instr(7'b0110011, 0, 0);
    // Load with three stall cycles in MEM_READ, and one in FETCH.
    run_instr(7'b0000011, 1, 3);
    // Store.
    run_instr(7'b0100011, 0, 2);
    // Illegal, then branch.
    run_instr(7'b1111111, 0, 0);
    run_instr(7'b1100011, 2, 0);
    run_instr(7'b0010011, 0, 0);

    // Reset in the middle of a stalled store.
    op = 7'b0100011;
    step(0, 7'd0, 1'b1, op);
    step(1, op, 1'b0, op);
    step(2, op, 1'b0, op);
    step(5, op, 1'b0, op);
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("midreset_state", {28'd0, state}, 32'd0);
    chk("midreset_outputs", {17'd0, w_obs}, 32'd0);
    chk("midreset_count", {16'd0, retired_count}, 32'd0);
    model_count = 16'd0;
    @(negedge clk);
    #1;
    chk("midreset_hold_outputs", {17'd0, w_obs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(7'b0110011, 1, 0);

    // Counter wrap: park the counter at FFFF while idling in FETCH.
    opcode    = 7'd0;
    mem_ready = 1'b0;
    force dut.r_retired_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_retired_count;
    model_count = 16'hFFFF;
    run_instr(7'b1111111, 0, 0);
    run_instr(7'b1100011, 0, 0);
    step(0, 7'd0, 1'b0, 7'd0);
    chk("wrap_count", {16'd0, retired_count}, 32'd0);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
